// File: rtl/dpi_stream_ctx_mgr.sv
// dpi_stream_ctx_mgr
// Per-stream context manager for one DPI regex matcher. Up to 2**SID_W interleaved
// streams share the matcher. Matcher state is saved at end of packet and restored at
// start of packet. Each stream has its own packet-match counter. The host reads the
// counters through a read/clear port.
// Build option: define DPI_CNT_SATURATE_EN to make counters saturate at all-ones
// instead of wrapping.
module dpi_stream_ctx_mgr #(
    parameter int STATE_W = 11,
    parameter int SID_W   = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_state,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               enable,
    input  logic               eop,
    input  logic               char_in_vld,
    output logic               mtch_char_vld,
    output logic [STATE_W-1:0] mtch_state_in,
    output logic               mtch_state_in_vld,
    input  logic [STATE_W-1:0] mtch_state_out,
    input  logic               mtch_accept,
    output logic               fired,
    input  logic               rd_req,
    input  logic [SID_W-1:0]   rd_sid,
    input  logic               rd_clr,
    output logic               rd_vld,
    output logic [CNT_W-1:0]   rd_count
);

    localparam int NSTR = 2 ** SID_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE,
        COMMIT
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [SID_W-1:0]   cur_sid;
    logic [SID_W-1:0]   commit_sid;
    logic               new_flag;
    logic               load_pend;
    logic               inc;
    logic               restore_zero;
    logic               eop_act;
    logic               save;

    logic [NSTR-1:0]    valid;
    logic [STATE_W-1:0] state_mem [NSTR];
    logic [CNT_W-1:0]   cnt       [NSTR];

    logic [NSTR-1:0]    commit_hit;
    logic [NSTR-1:0]    clr_hit;

    // Counter increment: wrap or saturate depending on build option.
    function automatic logic [CNT_W-1:0] cnt_add(input logic [CNT_W-1:0] c, input logic i);
`ifdef DPI_CNT_SATURATE_EN
        return (i && (c != '1)) ? c + CNT_W'(1) : c;
`else
        return c + CNT_W'(i);
`endif
    endfunction

    assign eop_act      = (state == ACTIVE) && eop;
    assign save         = eop_act && enable;
    assign restore_zero = new_flag || !valid[cur_sid];

    // Next-state decode and matcher-facing strobes.
    always_comb begin
        state_nxt         = state;
        mtch_char_vld     = 1'b0;
        mtch_state_in_vld = 1'b0;
        mtch_state_in     = '0;
        case (state)
            IDLE: begin
                if (load_state) state_nxt = LOAD;
            end
            LOAD: begin
                mtch_state_in_vld = 1'b1;
                mtch_state_in     = restore_zero ? '0 : state_mem[cur_sid];
                state_nxt         = load_state ? LOAD : ACTIVE;
            end
            ACTIVE: begin
                mtch_char_vld = char_in_vld;
                // A committing eop always passes through COMMIT; a load in the same
                // cycle is remembered in load_pend and taken from COMMIT.
                if (eop && enable)   state_nxt = COMMIT;
                else if (load_state) state_nxt = LOAD;
                else if (eop)        state_nxt = IDLE;
            end
            COMMIT: begin
                state_nxt = (load_state || load_pend) ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register and per-packet control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_sid    <= '0;
            commit_sid <= '0;
            new_flag   <= 1'b0;
            load_pend  <= 1'b0;
            inc        <= 1'b0;
            fired      <= 1'b0;
            valid      <= '0;
        end else begin
            state     <= state_nxt;
            load_pend <= save && load_state;
            if (load_state) begin
                cur_sid  <= stream_id;
                new_flag <= new_stream_id;
            end
            if (load_state) begin
                fired <= 1'b0;
            end else if (eop_act && !enable) begin
                fired <= 1'b0;
            end else if ((state == ACTIVE) && mtch_accept) begin
                fired <= 1'b1;
            end
            if (save) begin
                valid[cur_sid] <= 1'b1;
                commit_sid     <= cur_sid;
                inc            <= fired || mtch_accept;
            end
        end
    end

    // Matcher context storage; contents are masked by valid, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && save) begin
            state_mem[cur_sid] <= mtch_state_out;
        end
    end

    // One-hot decode of the counter touched by COMMIT and by a read-clear.
    always_comb begin
        commit_hit = '0;
        clr_hit    = '0;
        if (state == COMMIT) commit_hit[commit_sid] = 1'b1;
        if (rd_req && rd_clr) clr_hit[rd_sid] = 1'b1;
    end

    // Per-stream counters; a clear colliding with a commit keeps the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSTR; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSTR; i++) begin
                if (clr_hit[i]) begin
                    cnt[i] <= commit_hit[i] ? CNT_W'(inc) : '0;
                end else if (commit_hit[i]) begin
                    cnt[i] <= cnt_add(cnt[i], inc);
                end
            end
        end
    end

    // Host read port: returns the value held before this cycle's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld   <= 1'b0;
            rd_count <= '0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) begin
                rd_count <= cnt[rd_sid];
            end
        end
    end

endmodule

// File: tb/tb_dpi_stream_ctx_mgr.sv
// tb_dpi_stream_ctx_mgr
// Randomized bench for dpi_stream_ctx_mgr with a per-stream reference model
// (saved state, valid flag and count per stream). Honours DPI_CNT_SATURATE_EN.
module tb_dpi_stream_ctx_mgr;

    localparam int STATE_W = 11;
    localparam int SID_W   = 6;
    localparam int CNT_W   = 4;
    localparam int NSTR    = 1 << SID_W;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;
`ifdef DPI_CNT_SATURATE_EN
    localparam int unsigned SAT17_EXP = 15;
`else
    localparam int unsigned SAT17_EXP = 1;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_state = 1'b0;
    logic [SID_W-1:0]   stream_id = '0;
    logic               new_stream_id = 1'b0;
    logic               enable = 1'b0;
    logic               eop = 1'b0;
    logic               char_in_vld = 1'b0;
    logic               mtch_char_vld;
    logic [STATE_W-1:0] mtch_state_in;
    logic               mtch_state_in_vld;
    logic [STATE_W-1:0] mtch_state_out = '0;
    logic               mtch_accept = 1'b0;
    logic               fired;
    logic               rd_req = 1'b0;
    logic [SID_W-1:0]   rd_sid = '0;
    logic               rd_clr = 1'b0;
    logic               rd_vld;
    logic [CNT_W-1:0]   rd_count;

    dpi_stream_ctx_mgr #(
        .STATE_W(STATE_W),
        .SID_W  (SID_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .load_state       (load_state),
        .stream_id        (stream_id),
        .new_stream_id    (new_stream_id),
        .enable           (enable),
        .eop              (eop),
        .char_in_vld      (char_in_vld),
        .mtch_char_vld    (mtch_char_vld),
        .mtch_state_in    (mtch_state_in),
        .mtch_state_in_vld(mtch_state_in_vld),
        .mtch_state_out   (mtch_state_out),
        .mtch_accept      (mtch_accept),
        .fired            (fired),
        .rd_req           (rd_req),
        .rd_sid           (rd_sid),
        .rd_clr           (rd_clr),
        .rd_vld           (rd_vld),
        .rd_count         (rd_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // reference model
    logic [STATE_W-1:0] m_state [NSTR];
    bit                 m_valid [NSTR];
    int unsigned        m_cnt   [NSTR];
    bit                 m_fired = 1'b0;
    bit                 p_rd = 1'b0;
    int unsigned        p_cnt = 0;

    // expectations for the current cycle
    bit                 e_act = 1'b0;
    bit                 e_ld = 1'b0;
    logic [STATE_W-1:0] e_sin = '0;
    bit                 e_commit = 1'b0;
    int unsigned        e_csid = 0;
    bit                 e_inc = 1'b0;

    int unsigned        cur = 0;
    int unsigned        acc_prob = 100;
    bit                 rnd_rd = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned madd(input int unsigned c, input bit i);
`ifdef DPI_CNT_SATURATE_EN
        return (i && c < CMAX) ? c + 1 : c;
`else
        return (c + (i ? 1 : 0)) % (CMAX + 1);
`endif
    endfunction

    function automatic logic [STATE_W-1:0] restore_exp(input int unsigned sid, input bit nw);
        return (nw || !m_valid[sid]) ? '0 : m_state[sid];
    endfunction

    function automatic int unsigned pick_sid();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 3;
            2:       return 5;
            3:       return 7;
            4:       return 9;
            default: return $urandom_range(0, NSTR - 1);
        endcase
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, then drive defaults.
    task automatic cyc();
        @(negedge clk);
        check_val("char_vld", 32'(mtch_char_vld), 32'(e_act & char_in_vld));
        check_val("sin_vld", 32'(mtch_state_in_vld), 32'(e_ld));
        if (e_ld) check_val("sin", 32'(mtch_state_in), 32'(e_sin));
        check_val("fired", 32'(fired), 32'(m_fired));
        check_val("rd_vld", 32'(rd_vld), 32'(p_rd));
        if (p_rd) check_val("rd_count", 32'(rd_count), p_cnt);
        if (rst) begin
            for (int i = 0; i < NSTR; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 0;
            end
            m_fired = 1'b0;
            p_rd    = 1'b0;
        end else begin
            p_rd = rd_req;
            if (rd_req) begin
                p_cnt = m_cnt[rd_sid];
                if (rd_clr) m_cnt[rd_sid] = 0;
            end
            if (e_commit) m_cnt[e_csid] = madd(m_cnt[e_csid], e_inc);
            if (load_state)                 m_fired = 1'b0;
            else if (e_act && eop && !enable) m_fired = 1'b0;
            else if (e_act && mtch_accept)  m_fired = 1'b1;
        end
        @(posedge clk);
        #1;
        load_state     = 1'b0;
        eop            = 1'b0;
        rd_req         = 1'b0;
        rd_clr         = 1'b0;
        char_in_vld    = 1'($urandom_range(0, 1));
        mtch_accept    = ($urandom_range(0, 99) < acc_prob);
        mtch_state_out = STATE_W'($urandom);
        enable         = 1'($urandom_range(0, 1));
        stream_id      = SID_W'($urandom);
        new_stream_id  = 1'($urandom_range(0, 1));
        if (rnd_rd && $urandom_range(0, 3) == 0) begin
            rd_req = 1'b1;
            rd_sid = SID_W'(pick_sid());
            rd_clr = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc();
    endtask

    task automatic load_cycles(input int unsigned sid, input bit nw);
        load_state    = 1'b1;
        stream_id     = SID_W'(sid);
        new_stream_id = nw;
        cyc();
        e_act = 1'b0;
        e_ld  = 1'b1;
        e_sin = restore_exp(sid, nw);
        cyc();
        e_ld  = 1'b0;
        e_act = 1'b1;
        cur   = sid;
    endtask

    // chain: 0 none, 1 load together with eop, 2 load one cycle after eop
    task automatic end_pkt(input bit en, input int unsigned chain, input int unsigned nsid,
                           input bit nnew, input bit rc);
        bit inc;
        eop    = 1'b1;
        enable = en;
        if (chain == 1) begin
            load_state    = 1'b1;
            stream_id     = SID_W'(nsid);
            new_stream_id = nnew;
        end
        inc = m_fired | mtch_accept;
        if (en) begin
            m_state[cur] = mtch_state_out;
            m_valid[cur] = 1'b1;
        end
        cyc();
        e_act = 1'b0;
        if (en) begin
            e_commit = 1'b1;
            e_csid   = cur;
            e_inc    = inc;
            if (rc) begin
                rd_req = 1'b1;
                rd_clr = 1'b1;
                rd_sid = SID_W'(cur);
            end
        end
        if (chain == 2) begin
            load_state    = 1'b1;
            stream_id     = SID_W'(nsid);
            new_stream_id = nnew;
        end
        if (en || chain == 2) cyc();
        e_commit = 1'b0;
        if (chain != 0) begin
            e_ld  = 1'b1;
            e_sin = restore_exp(nsid, nnew);
            cyc();
            e_ld  = 1'b0;
            e_act = 1'b1;
            cur   = nsid;
        end
    endtask

    task automatic read_sid(input int unsigned sid, input bit clr);
        rd_req = 1'b1;
        rd_sid = SID_W'(sid);
        rd_clr = clr;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NSTR; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 0;
            m_state[i] = '0;
        end
        char_in_vld = 1'b1;
        mtch_accept = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_fired", 32'(fired), 32'd0);
        check_val("rst_sin_vld", 32'(mtch_state_in_vld), 32'd0);
        check_val("rst_sin", 32'(mtch_state_in), 32'd0);
        check_val("rst_char_vld", 32'(mtch_char_vld), 32'd0);
        check_val("rst_rd_vld", 32'(rd_vld), 32'd0);
        check_val("rst_rd_count", 32'(rd_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // new stream 3 with accepts, committed
        acc_prob = 100;
        load_cycles(3, 1'b1);
        idle(2);
        end_pkt(1'b1, 0, 0, 1'b0, 1'b0);
        idle(2);
        read_sid(3, 1'b0);
        check_val("t1_cnt3", 32'(rd_count), 32'd1);

        // restore stream 3, then drop the packet with enable low
        load_cycles(3, 1'b0);
        idle(1);
        end_pkt(1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
        read_sid(3, 1'b0);
        check_val("t4_cnt3", 32'(rd_count), 32'd1);
        load_cycles(3, 1'b0);
        end_pkt(1'b0, 0, 0, 1'b0, 1'b0);
        load_cycles(9, 1'b0);
        check_val("t2_sid9_sin", 32'(mtch_state_in), 32'd0);
        end_pkt(1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);

        // eop for 5 together with load for 7
        load_cycles(7, 1'b1);
        idle(1);
        end_pkt(1'b1, 0, 0, 1'b0, 1'b0);
        load_cycles(5, 1'b1);
        idle(1);
        end_pkt(1'b1, 1, 7, 1'b0, 1'b0);
        idle(1);
        end_pkt(1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
        read_sid(5, 1'b0);
        check_val("t5_cnt5", 32'(rd_count), 32'd1);

        // read-clear of 5 in the COMMIT cycle of 5
        load_cycles(5, 1'b0);
        idle(1);
        end_pkt(1'b1, 0, 0, 1'b0, 1'b1);
        check_val("t6_old5", 32'(rd_count), 32'd1);
        idle(1);
        read_sid(5, 1'b0);
        check_val("t6_cnt5", 32'(rd_count), 32'd1);

        // 17 matching packets on stream 0
        read_sid(0, 1'b1);
        for (int p = 0; p < 17; p++) begin
            load_cycles(0, 1'b0);
            idle(1);
            end_pkt(1'b1, 0, 0, 1'b0, 1'b0);
        end
        idle(1);
        read_sid(0, 1'b0);
        check_val("t7_sat17", 32'(rd_count), SAT17_EXP);
        idle(1);

        // random traffic
        rnd_rd = 1'b1;
        for (int p = 0; p < 200; p++) begin
            case ($urandom_range(0, 2))
                0:       acc_prob = 0;
                1:       acc_prob = 10;
                default: acc_prob = 50;
            endcase
            if (!e_act) begin
                idle($urandom_range(0, 2));
                load_cycles(pick_sid(), ($urandom_range(0, 3) == 0));
            end
            idle($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) begin
                load_cycles(pick_sid(), ($urandom_range(0, 3) == 0));
                idle($urandom_range(0, 3));
            end
            end_pkt(($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2),
                    pick_sid(), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
        end
        if (e_act) end_pkt(1'b1, 0, 0, 1'b0, 1'b0);
        rnd_rd = 1'b0;
        idle(2);

        // reset during a committing eop discards everything
        load_cycles(3, 1'b0);
        idle(1);
        rst    = 1'b1;
        eop    = 1'b1;
        enable = 1'b1;
        cyc();
        rst   = 1'b0;
        e_act = 1'b0;
        idle(1);
        read_sid(3, 1'b0);
        check_val("rst_cnt3", 32'(rd_count), 32'd0);
        read_sid(0, 1'b0);
        check_val("rst_cnt0", 32'(rd_count), 32'd0);
        load_cycles(3, 1'b0);
        end_pkt(1'b0, 0, 0, 1'b0, 1'b0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dpi_stream_ctx_mgr.md
# dpi_stream_ctx_mgr

Parametrised per-stream context manager for one DPI regex matcher. Saves and restores matcher state across packets of up to 2^SID_W interleaved streams, and keeps a per-stream packet-match counter instead of one global count. Sits between the packet parser (load/eop/stream id) and a matcher instance. The matcher instance sits outside this block and connects through the `mtch_*` ports. Counters are read back through a read/clear port for the host register block.

## Interface
- `STATE_W`, 11: matcher state width.
- `SID_W`, 6: stream id width; `NSTR = 2**SID_W` contexts.
- `CNT_W`, 16: per-stream counter width.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `load_state` in 1: start-of-packet pulse; samples `stream_id`/`new_stream_id`.
- `stream_id` in SID_W: stream of the packet.
- `new_stream_id` in 1: stream is new; start from state 0.
- `enable` in 1: regex enabled for this stream; sampled at `eop`.
- `eop` in 1: end-of-packet pulse.
- `char_in_vld` in 1: character valid from the parser.
- `mtch_char_vld` out 1: `char_in_vld` gated to ACTIVE.
- `mtch_state_in` out STATE_W: restore state to the matcher.
- `mtch_state_in_vld` out 1: one-cycle restore strobe.
- `mtch_state_out` in STATE_W: current matcher state.
- `mtch_accept` in 1: matcher accept.
- `fired` out 1: speculative match flag for the current packet.
- `rd_req` in 1: counter read request.
- `rd_sid` in SID_W: stream to read.
- `rd_clr` in 1: clear the counter on read; qualified by `rd_req`.
- `rd_vld` out 1: read data valid.
- `rd_count` out CNT_W: counter value.

## Operation
- FSM states: IDLE, LOAD, ACTIVE, COMMIT.
- `load_state` in any state:
  - Captures `cur_sid <= stream_id` and clears the `fired` flag.
  - Goes to LOAD.
  - In ACTIVE without `eop`, the open packet is aborted: no save, no count.
- LOAD, one cycle:
  - `mtch_state_in_vld = 1`.
  - `mtch_state_in = 0` if the new flag is set or `valid[cur_sid] == 0`; otherwise `state_mem[cur_sid]`.
  - Goes to ACTIVE.
- ACTIVE:
  - `mtch_char_vld = char_in_vld`. Outside ACTIVE it is 0 and characters are dropped.
  - `mtch_accept` sets `fired`. Once set, `fired` stays set until the next `load_state`, `enable==0` at `eop`, or reset.
- `eop` in ACTIVE:
  - `enable==1`: `state_mem[cur_sid] <= mtch_state_out`, `valid[cur_sid] <= 1`, `inc <= fired | mtch_accept`, go to COMMIT.
  - `enable==0`: `fired <= 0`, no save, go to IDLE.
- `eop` outside ACTIVE is ignored.
- COMMIT, one cycle:
  - `cnt[cur_sid] += inc`.
  - Goes to IDLE, or to LOAD if `load_state` is asserted in the same cycle.
- `eop` and `load_state` in the same cycle:
  - `eop` commits for the old `cur_sid`; COMMIT uses a latched copy of the old sid.
  - `load_state` starts the new packet.
  - LOAD follows COMMIT by one cycle; the parser holds characters until ACTIVE.
- Read port:
  - `rd_req` at cycle T gives `rd_vld=1` and `rd_count = cnt[rd_sid]` at T+1. The value is the pre-update value.
  - `rd_clr` writes 0.
  - If a clear and a COMMIT increment hit the same sid in the same cycle, the result is `inc`. The increment is never lost.
- Arithmetic:
  - Counter wraps modulo 2^CNT_W unless saturation is configured.
  - `inc` is 0 or 1.
- Reset values:
  - FSM in IDLE.
  - `fired`, `mtch_state_in_vld`, `mtch_char_vld`, `rd_vld` = 0.
  - `rd_count` = 0 and `mtch_state_in` = 0.
  - All `valid` bits = 0 and all counters = 0.
  - `state_mem` contents are not reset; `valid` masks them.
- Reset asserted mid-packet discards the packet: no save, no count.

## Timing
- `load_state` at T → `mtch_state_in_vld` at T+1 → ACTIVE from T+2.
- `eop` at E: state is saved at edge E.
- The counter updates at the edge ending E+1, so a read requested at E+2 returns the new value.
- `fired` is registered: it rises one cycle after `mtch_accept`.
- Any `mtch_accept` during cycle E counts toward the packet.
- Back-to-back packets need at least 3 cycles from `load_state` to `eop`.

## Configuration
- `DPI_CNT_SATURATE_EN` defined: each counter saturates at 2^CNT_W−1; further increments hold it there until a clear.
- `DPI_CNT_SATURATE_EN` undefined: each counter wraps to 0.

## Test plan
- Stream 3 is new, chars produce `mtch_accept`, `eop` with `enable=1` → `cnt[3]=1`; `valid[3]=1`; `state_mem[3]` equals `mtch_state_out` at `eop`.
- Stream 3 is loaded again with `new_stream_id=0` → `mtch_state_in` equals the saved state at T+1. Stream 9 has never been saved and is loaded with `new_stream_id=0` → `mtch_state_in=0`.
- `eop` with `enable=0` after an accept → `fired` drops to 0, `cnt` is unchanged, `state_mem` is unchanged.
- `eop` for sid 5 and `load_state` for sid 7 in the same cycle → `cnt[5]` increments and sid 7 is restored the cycle after COMMIT.
- Read-clear of sid 5 in the same cycle as a COMMIT increment to sid 5 → `rd_count` returns the old value and `cnt[5]=1` afterwards.
- With CNT_W=4, run 17 matching packets on sid 0 → final count is 15 with `DPI_CNT_SATURATE_EN`, 1 without.
